// File: rtl/conv_sched_pkg.sv
// Shared definitions for the convolution layer scheduler and the engine controller:
// engine mode codes, scheduler state type and error-cause encoding.
package conv_sched_pkg;

  localparam logic [2:0] CS_IDLE   = 3'd0;
  localparam logic [2:0] CS_BIAS   = 3'd1;
  localparam logic [2:0] CS_WEIGHT = 3'd2;
  localparam logic [2:0] CS_CONV3  = 3'd3;
  localparam logic [2:0] CS_CONVPW = 3'd4;
  localparam logic [2:0] CS_DRAIN  = 3'd5;
  localparam logic [2:0] CS_DONE   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = CS_IDLE,
    ST_BIAS   = CS_BIAS,
    ST_WEIGHT = CS_WEIGHT,
    ST_CONV3  = CS_CONV3,
    ST_CONVPW = CS_CONVPW,
    ST_DRAIN  = CS_DRAIN,
    ST_DONE   = CS_DONE
  } sched_state_e;

  // First error seen since the last accepted start.
  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_CFG       = 3'd1,
    ERR_STRAY_WB  = 3'd2,
    ERR_EXTRA_OUT = 3'd3,
    ERR_TIMEOUT   = 3'd4,
    ERR_ABORT     = 3'd5
  } err_cause_e;

endpackage

// File: rtl/conv_beat_counter.sv
// Loadable terminal-count beat counter: load sets the terminal and zeroes the count,
// increments saturate at the terminal.
module conv_beat_counter #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  input  logic             inc,
  output logic             at_terminal,
  output logic             at_terminal_next
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] term_q, term_d;

  assign at_terminal      = (cnt_q == term_q);
  assign at_terminal_next = (inc && !at_terminal) ? ((cnt_q + WIDTH'(1)) == term_q) : at_terminal;

  always_comb begin
    cnt_d  = cnt_q;
    term_d = term_q;
    if (load) begin
      term_d = load_value;
      cnt_d  = '0;
    end else if (clear) begin
      cnt_d = '0;
    end else if (inc && !at_terminal) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      term_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// Layer scheduler: walks one convolution engine through bias, weight, streaming and
// drain for every output-channel group, gating loader and pixel strobes into it.
module conv_layer_sched
  import conv_sched_pkg::*;
#(
  parameter int DIM_WIDTH     = 9,
  parameter int GROUP_WIDTH   = 6,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_WIDTH-1:0]   cfg_rows,
  input  logic [DIM_WIDTH-1:0]   cfg_cols,
  input  logic                   cfg_pw_mode,
  input  logic [GROUP_WIDTH-1:0] cfg_groups,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   wb_req,
  output logic [GROUP_WIDTH-1:0] wb_group,
  input  logic                   bias_valid_in,
  input  logic                   weight_valid_in,
  output logic                   bias_valid_out,
  output logic                   weight_valid_out,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic                   conv_valid_out,
  input  logic                   conv_out_valid,
  output logic [2:0]             current_state,
  input  logic                   state_rst
);

  localparam int CNT_W   = 2 * DIM_WIDTH;
  localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);

  sched_state_e           state_q, state_d;
  err_cause_e             cause_q, cause_d, evt_cause;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d, wb_req_q, wb_req_d;
  logic                   pw_q, pw_d;
  logic [GROUP_WIDTH-1:0] wb_group_q, wb_group_d, groups_q, groups_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;

  logic             cfg_ok, streaming, out_window, err_evt;
  logic             cnt_load, cnt_clear, in_inc, out_inc;
  logic             in_term, in_term_next, out_term, out_term_next;
  logic [CNT_W-1:0] rows_w, cols_w, in_total, out_total;

  assign rows_w    = CNT_W'(cfg_rows);
  assign cols_w    = CNT_W'(cfg_cols);
  assign in_total  = rows_w * cols_w;
  assign out_total = cfg_pw_mode ? in_total : (rows_w - CNT_W'(2)) * (cols_w - CNT_W'(2));
  assign cfg_ok    = (cfg_rows != '0) && (cfg_cols != '0) && (cfg_groups != '0) &&
                     (cfg_pw_mode || ((cfg_rows >= DIM_WIDTH'(3)) && (cfg_cols >= DIM_WIDTH'(3))));

  assign streaming        = (state_q == ST_CONV3) || (state_q == ST_CONVPW);
  assign out_window       = streaming || (state_q == ST_DRAIN);
  assign pix_ready        = streaming && !in_term;
  assign conv_valid_out   = pix_valid && pix_ready;
  assign in_inc           = conv_valid_out;
  assign out_inc          = out_window && conv_out_valid;
  assign bias_valid_out   = (state_q == ST_BIAS) && bias_valid_in;
  assign weight_valid_out = (state_q == ST_WEIGHT) && weight_valid_in;

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign wb_req        = wb_req_q;
  assign wb_group      = wb_group_q;
  assign current_state = state_q;

  conv_beat_counter #(.WIDTH(CNT_W)) u_in_cnt (
    .clk(clk), .rst(rst), .load(cnt_load), .load_value(in_total), .clear(cnt_clear),
    .inc(in_inc), .at_terminal(in_term), .at_terminal_next(in_term_next)
  );

  conv_beat_counter #(.WIDTH(CNT_W)) u_out_cnt (
    .clk(clk), .rst(rst), .load(cnt_load), .load_value(out_total), .clear(cnt_clear),
    .inc(out_inc), .at_terminal(out_term), .at_terminal_next(out_term_next)
  );

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cause_d    = cause_q;
    wb_group_d = wb_group_q;
    groups_d   = groups_q;
    pw_d       = pw_q;
    drain_d    = drain_q;
    cnt_load   = 1'b0;
    cnt_clear  = 1'b0;
    err_evt    = 1'b0;
    evt_cause  = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (start && cfg_ok) begin
          state_d    = ST_BIAS;
          cnt_load   = 1'b1;
          wb_group_d = '0;
          groups_d   = cfg_groups;
          pw_d       = cfg_pw_mode;
          drain_d    = '0;
          err_d      = 1'b0;
          cause_d    = ERR_NONE;
        end else if (start) begin
          done_d    = 1'b1;
          err_evt   = 1'b1;
          evt_cause = ERR_CFG;
        end
      end
      ST_BIAS:   if (bias_valid_in) state_d = ST_WEIGHT;
      ST_WEIGHT: if (weight_valid_in) state_d = pw_q ? ST_CONVPW : ST_CONV3;
      ST_CONV3, ST_CONVPW: begin
        if (in_term_next) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        // The beat arriving this cycle counts toward completion.
        if (out_term_next) begin
          if (wb_group_q < (groups_q - GROUP_WIDTH'(1))) begin
            wb_group_d = wb_group_q + GROUP_WIDTH'(1);
            cnt_clear  = 1'b1;
            state_d    = ST_BIAS;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else if (drain_q == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          err_evt   = 1'b1;
          evt_cause = ERR_TIMEOUT;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if ((bias_valid_in && (state_q != ST_BIAS)) || (weight_valid_in && (state_q != ST_WEIGHT))) begin
      err_evt   = 1'b1;
      evt_cause = ERR_STRAY_WB;
    end
    if (out_window && conv_out_valid && out_term) begin
      err_evt   = 1'b1;
      evt_cause = ERR_EXTRA_OUT;
    end

    // Engine-requested abort overrides whatever the state machine chose above.
    if (state_rst && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      done_d     = 1'b1;
      cnt_clear  = 1'b1;
      wb_group_d = '0;
      drain_d    = '0;
      err_evt    = 1'b1;
      evt_cause  = ERR_ABORT;
    end

    if (err_evt) begin
      err_d = 1'b1;
      if (cause_d == ERR_NONE) cause_d = evt_cause;
    end

    busy_d   = (state_d != ST_IDLE);
    wb_req_d = (state_d == ST_BIAS) || (state_d == ST_WEIGHT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cause_q    <= ERR_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wb_req_q   <= 1'b0;
      pw_q       <= 1'b0;
      wb_group_q <= '0;
      groups_q   <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wb_req_q   <= wb_req_d;
      pw_q       <= pw_d;
      wb_group_q <= wb_group_d;
      groups_q   <= groups_d;
      drain_q    <= drain_d;
    end
  end

endmodule
